ex_mem_pipe: RTL and testbench
==============================

Name: ex_mem_pipe

Overview:
- Parametrised EX/MEM pipeline register for the 5-stage core; successor to the fixed 32-bit EX/MEM latch.
- Carries the register-write, HI/LO-write and load/store payload from EX to MEM.
- Adds a per-stage valid bit, a flush input with priority over stall, and a configurable stall-vector position.
- Adds a saturating bubble counter and keeps the multi-cycle (madd/msub/div) carry-back path to EX.

Parameters:
- DATA_W, 32, register / HI / LO / address data width
- REG_ADDR_W, 5, destination register address width
- ALUOP_W, 8, ALU opcode width
- MC_CNT_W, 2, multi-cycle step counter width
- STALL_W, 6, width of stall vector from CTRL
- STAGE_IDX, 3, stall bit owned by EX; MEM's bit is STAGE_IDX+1 (must be < STALL_W)
- BCNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- stall  in  STALL_W  stall vector from CTRL
- flush  in  1  discard EX payload (exception / pipeline flush)
- ex_valid  in  1  EX holds a real instruction
- ex_wd / ex_wreg / ex_wdata  in  REG_ADDR_W / 1 / DATA_W  GPR write request
- ex_hi / ex_lo / ex_whilo  in  DATA_W / DATA_W / 1  HI/LO write request
- ex_aluop / ex_mem_addr / ex_reg2  in  ALUOP_W / DATA_W / DATA_W  load/store info
- hilo_i / cnt_i  in  2*DATA_W / MC_CNT_W  multi-cycle partial result and step from EX
- hilo_o / cnt_o  out  2*DATA_W / MC_CNT_W  partial result and step back to EX
- mem_valid  out  1  MEM-side valid
- mem_wd / mem_wreg / mem_wdata  out  registered GPR request
- mem_hi / mem_lo / mem_whilo  out  registered HI/LO request
- mem_aluop / mem_mem_addr / mem_reg2  out  registered load/store info
- bubble_cnt  out  BCNT_W  count of stall-inserted bubbles

Behaviour:
- All outputs are registered; latency is 1 cycle.
- Per-edge priority, highest first:
  1. rst==0: all outputs 0; mem_aluop = NOP opcode; mem_wd = NOP register address; bubble_cnt = 0.
  2. flush==1: MEM payload becomes a bubble; hilo_o = 0; cnt_o = 0; bubble_cnt unchanged. Flush beats every stall combination.
  3. stall[STAGE_IDX]==1 and stall[STAGE_IDX+1]==0: insert a bubble into MEM.
     - mem_valid = 0, all writes disabled, payload zeroed, mem_aluop = NOP.
     - hilo_o <= hilo_i, cnt_o <= cnt_i, so EX keeps its multi-cycle state.
     - bubble_cnt increments and saturates at all-ones.
  4. stall[STAGE_IDX]==0: capture all ex_* fields; mem_valid <= ex_valid; hilo_o = 0; cnt_o = 0.
  5. Otherwise (both stages stalled): hold the MEM payload and mem_valid; hilo_o = 0; cnt_o = 0.
- Bubble definition: mem_valid = 0, mem_wreg = 0, mem_whilo = 0, data fields 0.
- If ex_valid==0 on capture, the write-enables still pass through as given. EX guarantees they are 0.
- A multi-cycle operation in progress when rst goes low or flush rises is abandoned; the carry path returns to 0.
- No combinational path from any input to any output.

Optional Feature:
- Macro EX_MEM_EXCEPT_EN.
- Defined: adds exception-tracking ports.
  - Inputs ex_excepttype (32), ex_inst_addr (DATA_W), ex_in_delayslot (1).
  - Matching outputs mem_excepttype, mem_inst_addr, mem_in_delayslot.
  - These fields follow the same reset / flush / bubble / capture / hold rules; bubble and reset values are 0.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package / defines header holds:
  - NOP opcode constant, NOP register address, ZeroWord
  - Stop / NoStop encodings and RstEnable (=1'b0 for this block)
  - Bubble payload constant
- One natural sub-module: pipe_sat_cnt, a BCNT_W saturating counter with synchronous clear and increment enable.
- The register stage itself stays flat.

Test Plan:
1. rst=0 for 2 cycles with random inputs -> every output 0, mem_aluop=NOP, bubble_cnt=0.
2. Normal flow: stall=0, ex_wd=5'd7, ex_wdata=32'hDEADBEEF, ex_wreg=1, ex_valid=1 -> next cycle mem_wd=7, mem_wdata=DEADBEEF, mem_valid=1, hilo_o=0.
3. Madd stall: stall=6'b001111, hilo_i=64'h1_00000002, cnt_i=1 -> mem_valid=0, mem_wreg=0, hilo_o=64'h1_00000002, cnt_o=1, bubble_cnt +1. Then stall=0 -> cnt_o=0.
4. Hold: stall=6'b011111 after capturing wdata=32'h12345678 -> MEM outputs unchanged for 3 cycles, bubble_cnt unchanged.
5. Flush during bubble condition: flush=1, stall=6'b001111 -> bubble, cnt_o=0, hilo_o=0, bubble_cnt unchanged.
6. Saturation with BCNT_W=4: 20 consecutive bubble cycles -> bubble_cnt stays 4'hF.
   - Also, with EX_MEM_EXCEPT_EN: ex_excepttype=32'h8 captured, then cleared by flush.

Source files
------------

// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants and stage-action decode for the EX/MEM pipeline register.
// The bubble payload is assembled from the BUBBLE_* and NOP_* constants below.
package ex_mem_pipe_pkg;

    localparam logic        RST_ENABLE   = 1'b0;
    localparam logic        STOP         = 1'b1;
    localparam logic        NO_STOP      = 1'b0;

    localparam logic [7:0]  NOP_OP       = 8'h00;
    localparam logic [4:0]  NOP_REG_ADDR = 5'h00;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    // Bubble payload: nothing valid, every write disabled, data zero.
    localparam logic        BUBBLE_VALID = 1'b0;
    localparam logic        BUBBLE_WREG  = 1'b0;
    localparam logic        BUBBLE_WHILO = 1'b0;

    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_CAPTURE,
        ACT_HOLD
    } stage_act_e;

    // Flush wins over any stall pattern; EX stalled with MEM free opens a bubble.
    function automatic stage_act_e decode_act(input logic flush,
                                              input logic ex_stall,
                                              input logic mem_stall);
        if (flush)
            return ACT_FLUSH;
        if (ex_stall == STOP && mem_stall == NO_STOP)
            return ACT_BUBBLE;
        if (ex_stall == NO_STOP)
            return ACT_CAPTURE;
        return ACT_HOLD;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// Signal bundle between EX/CTRL (master) and the EX/MEM register (slave).
// Exception-tracking signals exist only when EX_MEM_EXCEPT_EN is defined.
interface ex_mem_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int MC_CNT_W   = 2,
    parameter int STALL_W    = 6,
    parameter int BCNT_W     = 16
);

    logic [STALL_W-1:0]    stall;
    logic                  flush;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_wd;
    logic                  ex_wreg;
    logic [DATA_W-1:0]     ex_wdata;
    logic [DATA_W-1:0]     ex_hi;
    logic [DATA_W-1:0]     ex_lo;
    logic                  ex_whilo;
    logic [ALUOP_W-1:0]    ex_aluop;
    logic [DATA_W-1:0]     ex_mem_addr;
    logic [DATA_W-1:0]     ex_reg2;
    logic [2*DATA_W-1:0]   hilo_i;
    logic [MC_CNT_W-1:0]   cnt_i;

    logic [2*DATA_W-1:0]   hilo_o;
    logic [MC_CNT_W-1:0]   cnt_o;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_wd;
    logic                  mem_wreg;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_hi;
    logic [DATA_W-1:0]     mem_lo;
    logic                  mem_whilo;
    logic [ALUOP_W-1:0]    mem_aluop;
    logic [DATA_W-1:0]     mem_mem_addr;
    logic [DATA_W-1:0]     mem_reg2;
    logic [BCNT_W-1:0]     bubble_cnt;

`ifdef EX_MEM_EXCEPT_EN
    logic [31:0]           ex_excepttype;
    logic [DATA_W-1:0]     ex_inst_addr;
    logic                  ex_in_delayslot;
    logic [31:0]           mem_excepttype;
    logic [DATA_W-1:0]     mem_inst_addr;
    logic                  mem_in_delayslot;
`endif

    modport master (
        output stall, flush, ex_valid, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo,
               ex_whilo, ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
`ifdef EX_MEM_EXCEPT_EN
        output ex_excepttype, ex_inst_addr, ex_in_delayslot,
        input  mem_excepttype, mem_inst_addr, mem_in_delayslot,
`endif
        input  hilo_o, cnt_o, mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi,
               mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2, bubble_cnt
    );

    modport slave (
        input  stall, flush, ex_valid, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo,
               ex_whilo, ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
`ifdef EX_MEM_EXCEPT_EN
        input  ex_excepttype, ex_inst_addr, ex_in_delayslot,
        output mem_excepttype, mem_inst_addr, mem_in_delayslot,
`endif
        output hilo_o, cnt_o, mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi,
               mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2, bubble_cnt
    );

endinterface

// File: rtl/ex_mem_pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with valid bit, flush, stall bubbles and the
// multi-cycle carry-back path to EX. EX_MEM_EXCEPT_EN adds exception fields.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int MC_CNT_W   = 2,
    parameter int STALL_W    = 6,
    parameter int STAGE_IDX  = 3,
    parameter int BCNT_W     = 16
) (
    input logic          clk,
    input logic          rst,
    ex_mem_pipe_if.slave bus
);

    localparam int MEM_IDX = STAGE_IDX + 1;

    if (MEM_IDX >= STALL_W) begin : g_bad_stage_idx
        $error("ex_mem_pipe: STAGE_IDX+1 must be below STALL_W");
    end

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [DATA_W-1:0]     wdata;
        logic [DATA_W-1:0]     hi;
        logic [DATA_W-1:0]     lo;
        logic                  whilo;
        logic [ALUOP_W-1:0]    aluop;
        logic [DATA_W-1:0]     mem_addr;
        logic [DATA_W-1:0]     reg2;
`ifdef EX_MEM_EXCEPT_EN
        logic [31:0]           excepttype;
        logic [DATA_W-1:0]     inst_addr;
        logic                  in_delayslot;
`endif
    } payload_t;

    function automatic payload_t bubble_payload();
        payload_t p;
        p          = '0;
        p.valid    = BUBBLE_VALID;
        p.wd       = REG_ADDR_W'(NOP_REG_ADDR);
        p.wreg     = BUBBLE_WREG;
        p.wdata    = DATA_W'(ZERO_WORD);
        p.hi       = DATA_W'(ZERO_WORD);
        p.lo       = DATA_W'(ZERO_WORD);
        p.whilo    = BUBBLE_WHILO;
        p.aluop    = ALUOP_W'(NOP_OP);
        p.mem_addr = DATA_W'(ZERO_WORD);
        p.reg2     = DATA_W'(ZERO_WORD);
        return p;
    endfunction

    // Reset and bubble leave MEM in the same state.
    localparam payload_t BUBBLE = bubble_payload();

    payload_t            pay_q, pay_d, ex_pay;
    logic [2*DATA_W-1:0] hilo_q, hilo_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    logic [BCNT_W-1:0]   bubble_cnt;
    stage_act_e          act;
    logic                unused_stall;

    // Only the EX and MEM bits of the stall vector matter here.
    assign unused_stall = ^bus.stall;

    assign act = decode_act(bus.flush, bus.stall[STAGE_IDX], bus.stall[MEM_IDX]);

    always_comb begin
        ex_pay              = BUBBLE;
        ex_pay.valid        = bus.ex_valid;
        ex_pay.wd           = bus.ex_wd;
        ex_pay.wreg         = bus.ex_wreg;
        ex_pay.wdata        = bus.ex_wdata;
        ex_pay.hi           = bus.ex_hi;
        ex_pay.lo           = bus.ex_lo;
        ex_pay.whilo        = bus.ex_whilo;
        ex_pay.aluop        = bus.ex_aluop;
        ex_pay.mem_addr     = bus.ex_mem_addr;
        ex_pay.reg2         = bus.ex_reg2;
`ifdef EX_MEM_EXCEPT_EN
        ex_pay.excepttype   = bus.ex_excepttype;
        ex_pay.inst_addr    = bus.ex_inst_addr;
        ex_pay.in_delayslot = bus.ex_in_delayslot;
`endif
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        pay_d  = pay_q;
        hilo_d = '0;
        cnt_d  = '0;
        unique case (act)
            ACT_FLUSH:   pay_d = BUBBLE;
            ACT_BUBBLE: begin
                pay_d  = BUBBLE;
                hilo_d = bus.hilo_i;
                cnt_d  = bus.cnt_i;
            end
            ACT_CAPTURE: pay_d = ex_pay;
            default:     pay_d = pay_q;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pay_q  <= BUBBLE;
            hilo_q <= '0;
            cnt_q  <= '0;
        end else begin
            pay_q  <= pay_d;
            hilo_q <= hilo_d;
            cnt_q  <= cnt_d;
        end
    end

    pipe_sat_cnt #(
        .W (BCNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .clr_i (rst == RST_ENABLE),
        .inc_i ((rst != RST_ENABLE) && (act == ACT_BUBBLE)),
        .cnt_o (bubble_cnt)
    );

    assign bus.hilo_o           = hilo_q;
    assign bus.cnt_o            = cnt_q;
    assign bus.mem_valid        = pay_q.valid;
    assign bus.mem_wd           = pay_q.wd;
    assign bus.mem_wreg         = pay_q.wreg;
    assign bus.mem_wdata        = pay_q.wdata;
    assign bus.mem_hi           = pay_q.hi;
    assign bus.mem_lo           = pay_q.lo;
    assign bus.mem_whilo        = pay_q.whilo;
    assign bus.mem_aluop        = pay_q.aluop;
    assign bus.mem_mem_addr     = pay_q.mem_addr;
    assign bus.mem_reg2         = pay_q.reg2;
    assign bus.bubble_cnt       = bubble_cnt;
`ifdef EX_MEM_EXCEPT_EN
    assign bus.mem_excepttype   = pay_q.excepttype;
    assign bus.mem_inst_addr    = pay_q.inst_addr;
    assign bus.mem_in_delayslot = pay_q.in_delayslot;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe (BCNT_W=4 so saturation is reachable);
// exception fields are checked when EX_MEM_EXCEPT_EN is defined.
module tb_ex_mem_pipe;

    localparam int BCNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   exp_bcnt;

    ex_mem_pipe_if #(.BCNT_W(BCNT_W)) bus ();

    ex_mem_pipe #(.BCNT_W(BCNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [4:0] wd, input logic wreg,
                            input logic [31:0] wdata, hi, lo, input logic whilo,
                            input logic [7:0] aluop, input logic [31:0] addr, reg2);
        bus.ex_valid    = v;
        bus.ex_wd       = wd;
        bus.ex_wreg     = wreg;
        bus.ex_wdata    = wdata;
        bus.ex_hi       = hi;
        bus.ex_lo       = lo;
        bus.ex_whilo    = whilo;
        bus.ex_aluop    = aluop;
        bus.ex_mem_addr = addr;
        bus.ex_reg2     = reg2;
    endtask

    task automatic check_mem(input string tag, input logic v, input logic [4:0] wd,
                             input logic wreg, input logic [31:0] wdata, hi, lo,
                             input logic whilo, input logic [7:0] aluop,
                             input logic [31:0] addr, reg2);
        check({tag, ".valid"}, 64'(bus.mem_valid),    64'(v));
        check({tag, ".wd"},    64'(bus.mem_wd),       64'(wd));
        check({tag, ".wreg"},  64'(bus.mem_wreg),     64'(wreg));
        check({tag, ".wdata"}, 64'(bus.mem_wdata),    64'(wdata));
        check({tag, ".hi"},    64'(bus.mem_hi),       64'(hi));
        check({tag, ".lo"},    64'(bus.mem_lo),       64'(lo));
        check({tag, ".whilo"}, 64'(bus.mem_whilo),    64'(whilo));
        check({tag, ".aluop"}, 64'(bus.mem_aluop),    64'(aluop));
        check({tag, ".addr"},  64'(bus.mem_mem_addr), 64'(addr));
        check({tag, ".reg2"},  64'(bus.mem_reg2),     64'(reg2));
    endtask

    task automatic check_bubble(input string tag);
        check_mem(tag, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 8'h00, 32'h0, 32'h0);
    endtask

    task automatic check_carry(input string tag, input logic [63:0] hilo,
                               input logic [1:0] cnt, input logic [3:0] bcnt);
        check({tag, ".hilo_o"},     bus.hilo_o,           hilo);
        check({tag, ".cnt_o"},      64'(bus.cnt_o),       64'(cnt));
        check({tag, ".bubble_cnt"}, 64'(bus.bubble_cnt),  64'(bcnt));
    endtask

`ifdef EX_MEM_EXCEPT_EN
    task automatic check_except(input string tag, input logic [31:0] et,
                                input logic [31:0] ia, input logic ds);
        check({tag, ".excepttype"},   64'(bus.mem_excepttype),   64'(et));
        check({tag, ".inst_addr"},    64'(bus.mem_inst_addr),    64'(ia));
        check({tag, ".in_delayslot"}, 64'(bus.mem_in_delayslot), 64'(ds));
    endtask
`endif

    initial begin
        // Reset with random inputs on every port
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.flush  = 1'($urandom());
            bus.stall  = 6'($urandom());
            drive_ex(1'($urandom()), 5'($urandom()), 1'($urandom()), $urandom(),
                     $urandom(), $urandom(), 1'($urandom()), 8'($urandom()),
                     $urandom(), $urandom());
            bus.hilo_i = {$urandom(), $urandom()};
            bus.cnt_i  = 2'($urandom());
`ifdef EX_MEM_EXCEPT_EN
            bus.ex_excepttype   = $urandom();
            bus.ex_inst_addr    = $urandom();
            bus.ex_in_delayslot = 1'($urandom());
`endif
            tick();
        end
        check_bubble("reset");
        check_carry("reset", 64'h0, 2'd0, 4'd0);
`ifdef EX_MEM_EXCEPT_EN
        check_except("reset", 32'h0, 32'h0, 1'b0);
`endif

        // Normal capture; carry path stays zero
        rst       = 1'b1;
        bus.flush = 1'b0;
        bus.stall = 6'b000000;
        drive_ex(1'b1, 5'd7, 1'b1, 32'hDEADBEEF, 32'h11111111, 32'h22222222, 1'b1,
                 8'h24, 32'h00001000, 32'h0000CAFE);
        bus.hilo_i = 64'h5;
        bus.cnt_i  = 2'd2;
`ifdef EX_MEM_EXCEPT_EN
        bus.ex_excepttype   = 32'h8;
        bus.ex_inst_addr    = 32'hBFC00100;
        bus.ex_in_delayslot = 1'b1;
`endif
        tick();
        check_mem("capture", 1'b1, 5'd7, 1'b1, 32'hDEADBEEF, 32'h11111111, 32'h22222222,
                  1'b1, 8'h24, 32'h00001000, 32'h0000CAFE);
        check_carry("capture", 64'h0, 2'd0, 4'd0);
`ifdef EX_MEM_EXCEPT_EN
        check_except("capture", 32'h8, 32'hBFC00100, 1'b1);
`endif

        // Multi-cycle stall: bubbles into MEM, partial result loops back to EX
        bus.stall  = 6'b001111;
        bus.hilo_i = 64'h1_00000002;
        bus.cnt_i  = 2'd1;
        tick();
        check_bubble("madd1");
        check_carry("madd1", 64'h1_00000002, 2'd1, 4'd1);
`ifdef EX_MEM_EXCEPT_EN
        check_except("madd1", 32'h0, 32'h0, 1'b0);
`endif
        bus.hilo_i = 64'h3_00000004;
        bus.cnt_i  = 2'd2;
        tick();
        check_carry("madd2", 64'h3_00000004, 2'd2, 4'd2);

        bus.stall = 6'b000000;
        drive_ex(1'b1, 5'd3, 1'b1, 32'h12345678, 32'hAAAA0000, 32'h0000BBBB, 1'b0,
                 8'h23, 32'h00002000, 32'h00000055);
        tick();
        check_mem("recapture", 1'b1, 5'd3, 1'b1, 32'h12345678, 32'hAAAA0000, 32'h0000BBBB,
                  1'b0, 8'h23, 32'h00002000, 32'h00000055);
        check_carry("recapture", 64'h0, 2'd0, 4'd2);

        // Both stages stalled: MEM holds while EX inputs change
        bus.stall = 6'b011111;
        drive_ex(1'b1, 5'd9, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h2, 1'b1, 8'h2B,
                 32'h00003000, 32'h00000077);
        bus.hilo_i = 64'h9;
        bus.cnt_i  = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_mem("hold", 1'b1, 5'd3, 1'b1, 32'h12345678, 32'hAAAA0000, 32'h0000BBBB,
                      1'b0, 8'h23, 32'h00002000, 32'h00000055);
            check_carry("hold", 64'h0, 2'd0, 4'd2);
        end
`ifdef EX_MEM_EXCEPT_EN
        check_except("hold", 32'h8, 32'hBFC00100, 1'b1);
`endif

        // Flush beats the bubble condition and does not count
        bus.flush = 1'b1;
        bus.stall = 6'b001111;
        tick();
        check_bubble("flush_bubble");
        check_carry("flush_bubble", 64'h0, 2'd0, 4'd2);
`ifdef EX_MEM_EXCEPT_EN
        check_except("flush_bubble", 32'h0, 32'h0, 1'b0);
`endif

        bus.flush = 1'b0;
        bus.stall = 6'b000000;
        tick();
        check_mem("cap2", 1'b1, 5'd9, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h2, 1'b1, 8'h2B,
                  32'h00003000, 32'h00000077);

        // Flush beats the hold condition and a free-flowing capture
        bus.flush = 1'b1;
        bus.stall = 6'b011111;
        tick();
        check_bubble("flush_hold");
        bus.stall = 6'b000000;
        tick();
        check_bubble("flush_cap");
        check_carry("flush_cap", 64'h0, 2'd0, 4'd2);

        // ex_valid=0 capture still passes the write-enable through
        bus.flush = 1'b0;
        drive_ex(1'b0, 5'd4, 1'b1, 32'h0000ABCD, 32'h0, 32'h0, 1'b0, 8'h21,
                 32'h00000004, 32'h0);
        tick();
        check_mem("novalid", 1'b0, 5'd4, 1'b1, 32'h0000ABCD, 32'h0, 32'h0, 1'b0, 8'h21,
                  32'h00000004, 32'h0);

        // Saturation: 20 bubble cycles starting from count 2
        bus.stall  = 6'b001111;
        bus.hilo_i = 64'h7;
        bus.cnt_i  = 2'd1;
        exp_bcnt   = 2;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_bcnt = (exp_bcnt == 15) ? 15 : exp_bcnt + 1;
            check_carry("sat", 64'h7, 2'd1, 4'(exp_bcnt));
        end

        // Unrelated stall bits do not affect the EX/MEM decision
        bus.stall = 6'b101000;
        tick();
        check_bubble("other_bits_bubble");
        check_carry("other_bits_bubble", 64'h7, 2'd1, 4'hF);
        bus.stall = 6'b110111;
        drive_ex(1'b1, 5'd1, 1'b1, 32'h00000011, 32'h0, 32'h0, 1'b0, 8'h22,
                 32'h00000008, 32'h0);
        tick();
        check_mem("mem_bit_only", 1'b1, 5'd1, 1'b1, 32'h00000011, 32'h0, 32'h0, 1'b0,
                  8'h22, 32'h00000008, 32'h0);
        check_carry("mem_bit_only", 64'h0, 2'd0, 4'hF);

        // Reset during a multi-cycle op abandons it
        bus.stall  = 6'b001111;
        bus.hilo_i = 64'h8;
        bus.cnt_i  = 2'd2;
        rst        = 1'b0;
        tick();
        check_bubble("reset_mid");
        check_carry("reset_mid", 64'h0, 2'd0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
